// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow controller.
//
// Contents:
//   phase_e        - 3-bit game phase encoding (IDLE..OVER), driven out on 'phase'
//   SCREEN_XRES/YRES, ball/paddle/lives defaults used as top-level parameter defaults
//   bcd_digit_t    - one BCD digit
//   bcd_score_t    - two-digit BCD score {tens, ones}
//   bcd_inc_sat()  - BCD increment that saturates at 99
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } phase_e;

  localparam int unsigned SCREEN_XRES     = 640;
  localparam int unsigned SCREEN_YRES     = 480;
  localparam int unsigned BALL_SIZE_DEF   = 8;
  localparam int unsigned BALL_SPEED_DEF  = 2;
  localparam int unsigned PADDLE_X_DEF    = 16;
  localparam int unsigned PADDLE_W_DEF    = 8;
  localparam int unsigned PADDLE_H_DEF    = 64;
  localparam int unsigned LIVES_INIT_DEF  = 3;
  localparam int unsigned MISS_FRAMES_DEF = 60;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_score_t;

  function automatic bcd_score_t bcd_inc_sat(input bcd_score_t s);
    bcd_score_t r;
    r = s;
    if (s.tens == 4'd9 && s.ones == 4'd9) begin
      r = s;
    end else if (s.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = s.tens + 4'd1;
    end else begin
      r.ones = s.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_edge_sync.sv
// Two-flop synchroniser followed by a single-cycle edge detector.
//
// Parameters:
//   RISING - 1: pulse on a low->high input transition (input idles low)
//            0: pulse on a high->low input transition (input idles high)
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset; flops return to the idle level
//   din   - asynchronous input
//   pulse - one-cycle pulse, high two clock edges after the input edge
module pong_edge_sync #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  localparam logic IDLE_LVL = !RISING;

  logic sync1, sync2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
      prev  <= IDLE_LVL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Decoded from two flops only, so the pulse is glitch-free and lasts
  // exactly one cycle.
  always_comb begin
    if (RISING) pulse = sync2 & ~prev;
    else        pulse = ~sync2 & prev;
  end

endmodule

// File: rtl/pong_game_sequencer.sv
// Game-flow controller for the single-player VGA pong system.
// Sequences IDLE -> SERVE -> PLAY -> MISS -> (SERVE | OVER) -> IDLE, moves the
// ball once per frame, resolves wall/paddle collisions, keeps BCD score and lives.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   vsync      - active-low frame sync from the CRT controller
//   serve      - asynchronous serve/start button
//   paddle_y   - paddle top line, used on frame_tick cycles only
//   ball_x     - ball left pixel
//   ball_y     - ball top line
//   score      - {tens, ones} BCD score
//   lives      - remaining lives
//   phase      - current phase encoding (pong_pkg::phase_e)
//   frame_tick - one-cycle pulse per frame (vsync falling edge)
//
// Build option: define PONG_SPEEDUP_EN to make the ball speed up by one pixel
// per frame after every four paddle hits (capped at 4, reset on serve).
module pong_game_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned XRES        = SCREEN_XRES,
  parameter int unsigned YRES        = SCREEN_YRES,
  parameter int unsigned BALL_SIZE   = BALL_SIZE_DEF,
  parameter int unsigned BALL_SPEED  = BALL_SPEED_DEF,
  parameter int unsigned PADDLE_X    = PADDLE_X_DEF,
  parameter int unsigned PADDLE_W    = PADDLE_W_DEF,
  parameter int unsigned PADDLE_H    = PADDLE_H_DEF,
  parameter int unsigned LIVES_INIT  = LIVES_INIT_DEF,
  parameter int unsigned MISS_FRAMES = MISS_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       serve,
  input  logic [9:0] paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] phase,
  output logic       frame_tick
);

  localparam logic [9:0]        CENTRE_X   = 10'((XRES - BALL_SIZE) / 2);
  localparam logic [9:0]        CENTRE_Y   = 10'((YRES - BALL_SIZE) / 2);
  localparam logic signed [10:0] X_MAX     = 11'(XRES - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX     = 11'(YRES - BALL_SIZE);
  localparam logic signed [10:0] PAD_EDGE  = 11'(PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] PAD_EDGE1 = 11'(PADDLE_X + PADDLE_W - 1);
  localparam logic [2:0]        SPEED_INIT = 3'(BALL_SPEED);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic tick;
  logic serve_pulse;

  pong_edge_sync #(.RISING(1'b0)) u_vsync_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (vsync),
    .pulse (tick)
  );

  pong_edge_sync #(.RISING(1'b1)) u_serve_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (serve),
    .pulse (serve_pulse)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  phase_e     state_q, state_d;
  logic [9:0] bx_q, bx_d;
  logic [9:0] by_q, by_d;
  logic       dx_neg_q, dx_neg_d;
  logic       dy_neg_q, dy_neg_d;
  bcd_score_t score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] miss_cnt_q, miss_cnt_d;
  logic [2:0] step;

`ifdef PONG_SPEEDUP_EN
  logic [2:0] speed_q, speed_d;
  logic [1:0] hits_q, hits_d;
  assign step = speed_q;
`else
  assign step = SPEED_INIT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bx_q       <= CENTRE_X;
      by_q       <= CENTRE_Y;
      dx_neg_q   <= 1'b0;
      dy_neg_q   <= 1'b0;
      score_q    <= '0;
      lives_q    <= 2'(LIVES_INIT);
      miss_cnt_q <= '0;
`ifdef PONG_SPEEDUP_EN
      speed_q    <= SPEED_INIT;
      hits_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      dx_neg_q   <= dx_neg_d;
      dy_neg_q   <= dy_neg_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      miss_cnt_q <= miss_cnt_d;
`ifdef PONG_SPEEDUP_EN
      speed_q    <= speed_d;
      hits_q     <= hits_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Motion and collision arithmetic (11-bit signed so that moves past the
  // left/top wall are visible as negative values)
  // ---------------------------------------------------------------------------
  logic signed [10:0] cur_x, cur_y, step_s, nx, ny;
  logic               overlap, hit, miss;

  always_comb begin
    cur_x  = signed'({1'b0, bx_q});
    cur_y  = signed'({1'b0, by_q});
    step_s = signed'({8'd0, step});
    nx     = dx_neg_q ? (cur_x - step_s) : (cur_x + step_s);
    ny     = dy_neg_q ? (cur_y - step_s) : (cur_y + step_s);

    // Vertical overlap uses the pre-move ball_y.
    overlap = (({1'b0, by_q} + 11'(BALL_SIZE)) > {1'b0, paddle_y}) &&
              ({1'b0, by_q} < ({1'b0, paddle_y} + 11'(PADDLE_H)));
    hit     = dx_neg_q && (nx <= PAD_EDGE) && (cur_x > PAD_EDGE1) && overlap;
    miss    = dx_neg_q && (nx < 11'sd0) && !hit;
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-value logic
  // ---------------------------------------------------------------------------
  logic load_centre;

  always_comb begin
    state_d     = state_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    score_d     = score_q;
    lives_d     = lives_q;
    miss_cnt_d  = miss_cnt_q;
    load_centre = 1'b0;
`ifdef PONG_SPEEDUP_EN
    speed_d     = speed_q;
    hits_d      = hits_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (serve_pulse) begin
          score_d     = '0;
          lives_d     = 2'(LIVES_INIT);
          state_d     = ST_SERVE;
          load_centre = 1'b1;
        end
      end

      ST_SERVE: begin
        // Serve has priority over a coincident frame_tick; no motion here.
        load_centre = 1'b1;
        if (serve_pulse) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (tick) begin
          // Vertical walls are independent of the horizontal outcome, so a
          // corner hit reflects on both axes.
          if (ny < 11'sd0) begin
            by_d     = '0;
            dy_neg_d = 1'b0;
          end else if (ny >= Y_MAX) begin
            // Reflect as soon as the ball touches the wall so it never
            // spends a frame parked against it.
            by_d     = Y_MAX[9:0];
            dy_neg_d = 1'b1;
          end else begin
            by_d     = ny[9:0];
          end

          if (hit) begin
            bx_d     = PAD_EDGE[9:0];
            dx_neg_d = 1'b0;
            score_d  = bcd_inc_sat(score_q);
`ifdef PONG_SPEEDUP_EN
            hits_d   = hits_q + 2'd1;
            if (hits_q == 2'd3 && speed_q < 3'd4) speed_d = speed_q + 3'd1;
`endif
          end else if (miss) begin
            bx_d       = '0;
            lives_d    = lives_q - 2'd1;
            miss_cnt_d = 8'(MISS_FRAMES);
            state_d    = ST_MISS;
          end else if (nx >= X_MAX) begin
            bx_d     = X_MAX[9:0];
            dx_neg_d = 1'b1;
          end else begin
            bx_d     = nx[9:0];
          end
        end
      end

      ST_MISS: begin
        if (tick) begin
          // The tick that would bring the count to zero also leaves MISS.
          if (miss_cnt_q <= 8'd1) begin
            miss_cnt_d = '0;
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d     = ST_SERVE;
              load_centre = 1'b1;
            end
          end else begin
            miss_cnt_d = miss_cnt_q - 8'd1;
          end
        end
      end

      ST_OVER: begin
        if (serve_pulse) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (load_centre) begin
      bx_d     = CENTRE_X;
      by_d     = CENTRE_Y;
      dx_neg_d = 1'b0;
      dy_neg_d = 1'b0;
`ifdef PONG_SPEEDUP_EN
      speed_d  = SPEED_INIT;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ball_x     = bx_q;
  assign ball_y     = by_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign phase      = state_q;
  assign frame_tick = tick;

endmodule
